// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for one shared memory port: fetch (i_*) versus MEM stage (d_*).
// The winning command is registered onto pm_* and held until the memory completes.
module mem_port_arbiter #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_read,
    input  logic [ADDR_W-1:0]   i_address,
    output logic [DATA_W-1:0]   i_rdata,
    output logic                i_resp,
    input  logic                d_read,
    input  logic                d_write,
    input  logic [ADDR_W-1:0]   d_address,
    input  logic [DATA_W-1:0]   d_wdata,
    input  logic [DATA_W/8-1:0] d_byte_enable,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                d_resp,
    output logic                pm_read,
    output logic                pm_write,
    output logic [ADDR_W-1:0]   pm_address,
    output logic [DATA_W-1:0]   pm_wdata,
    output logic [DATA_W/8-1:0] pm_byte_enable,
    input  logic [DATA_W-1:0]   pm_rdata,
    input  logic                pm_resp
);

    localparam int unsigned BeW = DATA_W / 8;

    typedef enum logic [1:0] {StIdle, StServeI, StServeD} state_e;

    state_e              r_state;
    state_e              w_state_d;
    logic                r_last_grant;
    logic                w_last_grant_d;
    logic                r_pm_read;
    logic                w_pm_read_d;
    logic                r_pm_write;
    logic                w_pm_write_d;
    logic [ADDR_W-1:0]   r_pm_address;
    logic [ADDR_W-1:0]   w_pm_address_d;
    logic [DATA_W-1:0]   r_pm_wdata;
    logic [DATA_W-1:0]   w_pm_wdata_d;
    logic [BeW-1:0]      r_pm_byte_enable;
    logic [BeW-1:0]      w_pm_byte_enable_d;

    logic w_i_req;
    logic w_d_req;
    logic w_grant_i;
    logic w_grant_d;

    assign w_i_req = i_read;
    assign w_d_req = d_read | d_write;
    // On a tie, serve the side opposite the one served last (last_grant: 0=I, 1=D).
    assign w_grant_d = w_d_req & (~w_i_req | ~r_last_grant);
    assign w_grant_i = w_i_req & ~w_grant_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state          <= StIdle;
            r_last_grant     <= 1'b0;
            r_pm_read        <= 1'b0;
            r_pm_write       <= 1'b0;
            r_pm_address     <= '0;
            r_pm_wdata       <= '0;
            r_pm_byte_enable <= '0;
        end else begin
            r_state          <= w_state_d;
            r_last_grant     <= w_last_grant_d;
            r_pm_read        <= w_pm_read_d;
            r_pm_write       <= w_pm_write_d;
            r_pm_address     <= w_pm_address_d;
            r_pm_wdata       <= w_pm_wdata_d;
            r_pm_byte_enable <= w_pm_byte_enable_d;
        end
    end

    always_comb begin
        w_state_d          = r_state;
        w_last_grant_d     = r_last_grant;
        w_pm_read_d        = r_pm_read;
        w_pm_write_d       = r_pm_write;
        w_pm_address_d     = r_pm_address;
        w_pm_wdata_d       = r_pm_wdata;
        w_pm_byte_enable_d = r_pm_byte_enable;

        unique case (r_state)
            StIdle: begin
                if (w_grant_d) begin
                    w_state_d      = StServeD;
                    w_last_grant_d = 1'b1;
                    w_pm_address_d = d_address;
                    // A simultaneous read and write from the data side issues the write.
                    if (d_write) begin
                        w_pm_read_d        = 1'b0;
                        w_pm_write_d       = 1'b1;
                        w_pm_wdata_d       = d_wdata;
                        w_pm_byte_enable_d = d_byte_enable;
                    end else begin
                        w_pm_read_d        = 1'b1;
                        w_pm_write_d       = 1'b0;
                        w_pm_wdata_d       = '0;
                        w_pm_byte_enable_d = '1;
                    end
                end else if (w_grant_i) begin
                    w_state_d          = StServeI;
                    w_last_grant_d     = 1'b0;
                    w_pm_address_d     = i_address;
                    w_pm_read_d        = 1'b1;
                    w_pm_write_d       = 1'b0;
                    w_pm_wdata_d       = '0;
                    w_pm_byte_enable_d = '1;
                end else begin
                    w_pm_read_d  = 1'b0;
                    w_pm_write_d = 1'b0;
                end
            end
            StServeI, StServeD: begin
                if (pm_resp) begin
                    w_state_d    = StIdle;
                    w_pm_read_d  = 1'b0;
                    w_pm_write_d = 1'b0;
                end
            end
            default: begin
                w_state_d    = StIdle;
                w_pm_read_d  = 1'b0;
                w_pm_write_d = 1'b0;
            end
        endcase
    end

    // Completion is steered combinationally so the requester sees it in the pm_resp cycle.
    always_comb begin
        i_resp  = (r_state == StServeI) & pm_resp;
        d_resp  = (r_state == StServeD) & pm_resp;
        i_rdata = i_resp ? pm_rdata : '0;
        d_rdata = d_resp ? pm_rdata : '0;
    end

    assign pm_read        = r_pm_read;
    assign pm_write       = r_pm_write;
    assign pm_address     = r_pm_address;
    assign pm_wdata       = r_pm_wdata;
    assign pm_byte_enable = r_pm_byte_enable;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: grant order, command contents, response steering
// and asynchronous reset, all against hand-computed expectations.
module tb_mem_port_arbiter;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;

    logic                clk;
    logic                rst;
    logic                i_read;
    logic [ADDR_W-1:0]   i_address;
    logic [DATA_W-1:0]   i_rdata;
    logic                i_resp;
    logic                d_read;
    logic                d_write;
    logic [ADDR_W-1:0]   d_address;
    logic [DATA_W-1:0]   d_wdata;
    logic [DATA_W/8-1:0] d_byte_enable;
    logic [DATA_W-1:0]   d_rdata;
    logic                d_resp;
    logic                pm_read;
    logic                pm_write;
    logic [ADDR_W-1:0]   pm_address;
    logic [DATA_W-1:0]   pm_wdata;
    logic [DATA_W/8-1:0] pm_byte_enable;
    logic [DATA_W-1:0]   pm_rdata;
    logic                pm_resp;

    int checks;
    int errors;

    mem_port_arbiter #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .i_read        (i_read),
        .i_address     (i_address),
        .i_rdata       (i_rdata),
        .i_resp        (i_resp),
        .d_read        (d_read),
        .d_write       (d_write),
        .d_address     (d_address),
        .d_wdata       (d_wdata),
        .d_byte_enable (d_byte_enable),
        .d_rdata       (d_rdata),
        .d_resp        (d_resp),
        .pm_read       (pm_read),
        .pm_write      (pm_write),
        .pm_address    (pm_address),
        .pm_wdata      (pm_wdata),
        .pm_byte_enable(pm_byte_enable),
        .pm_rdata      (pm_rdata),
        .pm_resp       (pm_resp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        rst           = 1'b0;
        i_read        = 1'b0;
        i_address     = '0;
        d_read        = 1'b0;
        d_write       = 1'b0;
        d_address     = '0;
        d_wdata       = '0;
        d_byte_enable = '0;
        pm_resp       = 1'b1;
        pm_rdata      = 32'hFFFF_FFFF;

        // Reset state, with a stray pm_resp that must not leak through
        #2;
        chk("rst_pm_read", pm_read, 0);
        chk("rst_pm_write", pm_write, 0);
        chk("rst_pm_address", pm_address, 0);
        chk("rst_pm_wdata", pm_wdata, 0);
        chk("rst_pm_be", pm_byte_enable, 0);
        chk("rst_i_resp", i_resp, 0);
        chk("rst_d_resp", d_resp, 0);
        chk("rst_i_rdata", i_rdata, 0);
        chk("rst_d_rdata", d_rdata, 0);
        cyc();
        cyc();
        rst     = 1'b1;
        pm_resp = 1'b1;
        #1;
        chk("idle_resp_ignored_i", i_resp, 0);
        chk("idle_resp_ignored_d", d_resp, 0);
        cyc();
        pm_resp = 1'b0;

        // Lone fetch
        i_read    = 1'b1;
        i_address = 32'h60;
        #1;
        cyc();
        chk("fetch_pm_read", pm_read, 1);
        chk("fetch_pm_write", pm_write, 0);
        chk("fetch_pm_address", pm_address, 32'h60);
        chk("fetch_pm_be", pm_byte_enable, 4'hF);
        chk("fetch_no_early_resp", i_resp, 0);
        cyc();
        pm_resp  = 1'b1;
        pm_rdata = 32'h0000_0013;
        #1;
        chk("fetch_i_resp", i_resp, 1);
        chk("fetch_i_rdata", i_rdata, 32'h13);
        chk("fetch_d_resp", d_resp, 0);
        chk("fetch_d_rdata", d_rdata, 0);
        cyc();
        pm_resp = 1'b0;
        i_read  = 1'b0;
        #1;
        chk("fetch_pm_read_drop", pm_read, 0);
        chk("fetch_i_resp_drop", i_resp, 0);

        // Lone store
        d_write       = 1'b1;
        d_address     = 32'h1004;
        d_wdata       = 32'hDEAD_BEEF;
        d_byte_enable = 4'b0100;
        cyc();
        chk("store_pm_write", pm_write, 1);
        chk("store_pm_read", pm_read, 0);
        chk("store_pm_address", pm_address, 32'h1004);
        chk("store_pm_wdata", pm_wdata, 32'hDEAD_BEEF);
        chk("store_pm_be", pm_byte_enable, 4'b0100);
        chk("store_d_resp_early", d_resp, 0);
        cyc();
        pm_resp  = 1'b1;
        pm_rdata = 32'h77;
        #1;
        chk("store_d_resp", d_resp, 1);
        chk("store_i_resp", i_resp, 0);
        cyc();
        pm_resp = 1'b0;
        d_write = 1'b0;
        #1;
        chk("store_pm_write_drop", pm_write, 0);
        chk("store_d_resp_once", d_resp, 0);
        cyc();
        chk("store_d_resp_once2", d_resp, 0);
        chk("store_idle_pm_write", pm_write, 0);

        // Tie from reset: D first, one IDLE cycle, then I
        #2;
        rst = 1'b0;
        cyc();
        rst       = 1'b1;
        i_read    = 1'b1;
        i_address = 32'h100;
        d_read    = 1'b1;
        d_address = 32'h200;
        cyc();
        chk("tie_first_pm_read", pm_read, 1);
        chk("tie_first_pm_write", pm_write, 0);
        chk("tie_first_is_d", pm_address, 32'h200);
        cyc();
        pm_resp  = 1'b1;
        pm_rdata = 32'hAAAA;
        #1;
        chk("tie_d_resp", d_resp, 1);
        chk("tie_d_rdata", d_rdata, 32'hAAAA);
        chk("tie_i_resp_quiet", i_resp, 0);
        chk("tie_i_rdata_quiet", i_rdata, 0);
        cyc();
        pm_resp = 1'b0;
        d_read  = 1'b0;
        #1;
        chk("tie_gap_idle", pm_read, 0);
        cyc();
        chk("tie_second_pm_read", pm_read, 1);
        chk("tie_second_is_i", pm_address, 32'h100);
        cyc();
        pm_resp  = 1'b1;
        pm_rdata = 32'h5555;
        #1;
        chk("tie_i_resp", i_resp, 1);
        chk("tie_i_rdata", i_rdata, 32'h5555);
        chk("tie_d_resp_quiet", d_resp, 0);
        cyc();
        pm_resp = 1'b0;
        i_read  = 1'b0;
        #1;
        chk("tie_end_idle", pm_read, 0);

        // Sustained contention, zero-latency memory: D, I, D, I, D, I
        i_read    = 1'b1;
        i_address = 32'h1000;
        d_read    = 1'b1;
        d_address = 32'h2000;
        for (int n = 0; n < 6; n++) begin
            cyc();
            chk("rr_pm_read", pm_read, 1);
            chk("rr_pm_address", pm_address, (n % 2 == 0) ? 32'h2000 : 32'h1000);
            pm_resp  = 1'b1;
            pm_rdata = 32'hC0 + n;
            #1;
            chk("rr_d_resp", d_resp, (n % 2 == 0) ? 1 : 0);
            chk("rr_i_resp", i_resp, (n % 2 == 0) ? 0 : 1);
            cyc();
            pm_resp = 1'b0;
            #1;
            chk("rr_idle_gap", pm_read, 0);
        end
        i_read = 1'b0;
        d_read = 1'b0;

        // Slow memory: five cycles without response, other side changes meanwhile
        d_write       = 1'b1;
        d_address     = 32'h3000;
        d_wdata       = 32'h1234_5678;
        d_byte_enable = 4'hF;
        for (int j = 0; j < 5; j++) begin
            cyc();
            if (j == 1) begin
                d_address = 32'h4444;
                i_read    = 1'b1;
                i_address = 32'h500;
            end
            #1;
            chk("slow_pm_write", pm_write, 1);
            chk("slow_pm_address", pm_address, 32'h3000);
            chk("slow_pm_wdata", pm_wdata, 32'h1234_5678);
            chk("slow_d_resp_wait", d_resp, 0);
        end
        cyc();
        pm_resp = 1'b1;
        #1;
        chk("slow_d_resp", d_resp, 1);
        chk("slow_addr_held", pm_address, 32'h3000);
        cyc();
        pm_resp = 1'b0;
        d_write = 1'b0;
        #1;
        chk("slow_idle_write", pm_write, 0);
        chk("slow_idle_read", pm_read, 0);
        cyc();
        chk("slow_next_i_read", pm_read, 1);
        chk("slow_next_i_addr", pm_address, 32'h500);
        pm_resp  = 1'b1;
        pm_rdata = 32'h600D;
        #1;
        chk("slow_i_resp", i_resp, 1);
        cyc();
        pm_resp = 1'b0;
        i_read  = 1'b0;
        #1;

        // Reset asserted mid-SERVE_D
        d_write       = 1'b1;
        d_address     = 32'h6000;
        d_wdata       = 32'hCAFE_F00D;
        d_byte_enable = 4'b0011;
        cyc();
        chk("mid_pm_write", pm_write, 1);
        #2;
        rst     = 1'b0;
        pm_resp = 1'b1;
        #1;
        chk("mid_rst_pm_write", pm_write, 0);
        chk("mid_rst_pm_address", pm_address, 0);
        chk("mid_rst_pm_wdata", pm_wdata, 0);
        chk("mid_rst_pm_be", pm_byte_enable, 0);
        chk("mid_rst_d_resp", d_resp, 0);
        cyc();
        rst      = 1'b1;
        d_write  = 1'b0;
        pm_resp  = 1'b1;
        pm_rdata = 32'h99;
        #1;
        chk("late_resp_d_resp", d_resp, 0);
        chk("late_resp_d_rdata", d_rdata, 0);
        chk("late_resp_i_resp", i_resp, 0);
        pm_resp   = 1'b0;
        i_read    = 1'b1;
        i_address = 32'h700;
        d_read    = 1'b1;
        d_address = 32'h800;
        cyc();
        chk("post_rst_tie_read", pm_read, 1);
        chk("post_rst_tie_is_d", pm_address, 32'h800);
        pm_resp = 1'b1;
        #1;
        chk("post_rst_d_resp", d_resp, 1);
        cyc();
        pm_resp = 1'b0;
        i_read  = 1'b0;
        d_read  = 1'b0;
        #1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbitrates one shared memory port between two requesters: the fetch side (`i_*`) and the MEM stage (`d_*`). The MEM stage's `dmem_*` bus drives the `d_*` port. The arbiter registers the winning request onto the `pm_*` port and holds it until the memory responds. It routes the response back to the granted requester only. Contention is resolved round-robin, and a tie from reset goes to the data side.

## Interface
- `ADDR_W`, default 32: address width.
- `DATA_W`, default 32: data width. `DATA_W/8` byte enables.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-low reset (asserted when 0).
- `i_read`  in  1  fetch read request; held until `i_resp`.
- `i_address`  in  ADDR_W  fetch address.
- `i_rdata`  out  DATA_W  fetch read data; valid when `i_resp`=1.
- `i_resp`  out  1  fetch transaction complete.
- `d_read`  in  1  data read request; held until `d_resp`.
- `d_write`  in  1  data write request; held until `d_resp`.
- `d_address`  in  ADDR_W  data address, word aligned.
- `d_wdata`  in  DATA_W  store data.
- `d_byte_enable`  in  DATA_W/8  store byte mask.
- `d_rdata`  out  DATA_W  data read data; valid when `d_resp`=1.
- `d_resp`  out  1  data transaction complete.
- `pm_read`, `pm_write`  out  1  shared-port command; registered.
- `pm_address`  out  ADDR_W  registered address.
- `pm_wdata`  out  DATA_W  registered write data.
- `pm_byte_enable`  out  DATA_W/8  registered mask; all-ones for reads.
- `pm_rdata`  in  DATA_W  memory read data.
- `pm_resp`  in  1  memory completion; one-cycle pulse.

## Operation
- States: IDLE, SERVE_I, SERVE_D. A 1-bit register `last_grant` records the last side served (0=I, 1=D).
- IDLE:
  - `i_req` = `i_read`; `d_req` = `d_read` | `d_write`.
  - Only one side requesting: grant that side.
  - Both requesting: grant the side opposite `last_grant`.
  - On grant, at the next edge:
    - Load the `pm_*` registers from the granted side.
    - Enter SERVE_x and set `last_grant` to the granted side.
  - No request: stay in IDLE with `pm_read`=`pm_write`=0.
- Command fields on grant:
  - I grant: `pm_read`=1, `pm_write`=0, `pm_wdata`=0, `pm_byte_enable`=all-ones.
  - D grant with `d_write`=1: `pm_write`=1, `pm_read`=0. If `d_read` and `d_write` are both 1, the write wins.
  - D grant with a read: `pm_read`=1.
- SERVE_x:
  - `pm_*` registers are frozen; requester input changes are ignored.
  - On `pm_resp`=1, in the same cycle:
    - `x_resp`=1 and `x_rdata`=`pm_rdata`. This path is combinational.
    - The other side's `resp` stays 0 and its `rdata` stays 0.
  - At the next edge: `pm_read`=`pm_write`=0, and the state returns to IDLE.
- `pm_resp` while in IDLE is ignored; no requester `resp` fires.
- A requester that drops its request mid-transaction is a protocol violation. The transaction still completes and `resp` still pulses.

## Timing
- Reset values:
  - `pm_read`=`pm_write`=0; `pm_address`=`pm_wdata`=`pm_byte_enable`=0.
  - `i_resp`=`d_resp`=0; `i_rdata`=`d_rdata`=0.
  - State IDLE; `last_grant`=0 (I), so the first tie goes to D.
- Latency, with a request first seen in IDLE at cycle t:
  - `pm_read`/`pm_write` high from cycle t+1.
  - If `pm_resp` arrives at cycle t+1+k (k≥0), `x_resp` is high at t+1+k.
  - IDLE is re-entered at t+2+k.
- Minimum occupancy is 2 cycles per transaction, because one IDLE cycle is mandatory between grants. That IDLE cycle lets the completed requester drop or change its request before it is sampled again.
- Sustained contention alternates D, I, D, I…; neither side waits for more than one other transaction.
- Reset asserted mid-transaction:
  - All outputs go to reset values immediately (asynchronously).
  - The outstanding memory transaction is abandoned. Any `pm_resp` after reset release, while in IDLE, is ignored.

## Test plan
- Lone fetch: `i_read`=1, `i_address`=0x60 at cycle 0; memory responds one cycle after `pm_read` with 0x00000013. Required: `pm_read`=1 and `pm_address`=0x60 at cycle 1; `i_resp`=1 and `i_rdata`=0x13 at cycle 2; `pm_read`=0 at cycle 3; `d_resp` never asserts.
- Lone store: `d_write`=1, `d_address`=0x1004, `d_wdata`=0xDEADBEEF, `d_byte_enable`=0b0100. Required: the `pm_*` command mirrors these values with `pm_read`=0; `d_resp` pulses exactly once.
- Tie from reset: `i_read` and `d_read` both assert on the first cycle after reset. Required: D is served first and I second, and the two `pm_*` commands are separated by exactly one IDLE cycle.
- Sustained contention: both sides request continuously for 6 transactions. Required grant order D, I, D, I, D, I.
- Slow memory: `pm_resp` is delayed 5 cycles. Required: `pm_*` stays stable for all 5 cycles; a request change from the other side is not seen until the IDLE cycle that follows.
- Reset mid-SERVE_D: `rst`=0 is asserted while a store is outstanding. Required: `pm_write` drops immediately. After release, a late `pm_resp` produces no `d_resp`, and the next tie is granted to D.
